// File: rtl/FPU_pkg.sv
// FPU_pkg: shared FPU op/rounding-mode encodings and integer-to-float constants.
package FPU_pkg;
    localparam logic [4:0] FPU_OP_CVTFI = 5'd10;
    localparam logic [4:0] FPU_OP_CVTFU = 5'd11;
    localparam logic [4:0] FPU_OP_CVTIF = 5'd12;
    localparam logic [4:0] FPU_OP_CVTUF = 5'd13;

    localparam logic [2:0] FPU_RM_RNE = 3'd0;
    localparam logic [2:0] FPU_RM_RTZ = 3'd1;
    localparam logic [2:0] FPU_RM_RDN = 3'd2;
    localparam logic [2:0] FPU_RM_RUP = 3'd3;
    localparam logic [2:0] FPU_RM_RMM = 3'd4;

    // 31 + binary32 bias
    localparam logic [7:0] ITOF_EXP_BASE = 8'd158;

    typedef struct packed {
        logic        sgn;
        logic [31:0] norm;
        logic [7:0]  exp;
        logic        zero;
        logic [2:0]  rm;
    } itof_s1_t;
endpackage

// File: rtl/leading_zero_counter.sv
// leading_zero_counter: combinational leading-zero count with all-zero flag.
module leading_zero_counter #(
    parameter int WIDTH = 32,
    localparam int CW = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] in,
    output logic [CW-1:0]    count,
    output logic             zero
);
    // Ascending scan so the most significant set bit decides the count.
    always_comb begin
        count = '0;
        for (int i = 0; i < WIDTH; i++)
            if (in[i]) count = CW'(WIDTH - 1 - i);
    end

    assign zero = ~|in;
endmodule

// File: rtl/rounding_logic.sv
// rounding_logic: IEEE-754 mantissa rounding increment with carry-out and inexact flag.
module rounding_logic
    import FPU_pkg::*;
#(
    parameter int WIDTH = 24
) (
    input  logic [WIDTH-1:0] in,
    input  logic             sgn,
    input  logic             round_bit,
    input  logic             sticky_bit,
    input  logic [2:0]       rm,
    output logic [WIDTH-1:0] out,
    output logic             carry,
    output logic             inexact
);
    logic up;

    assign inexact = round_bit | sticky_bit;
    // Reserved encodings fall through to round-to-nearest-even.
    assign up = (rm == FPU_RM_RTZ) ? 1'b0 :
                (rm == FPU_RM_RDN) ? inexact & sgn :
                (rm == FPU_RM_RUP) ? inexact & ~sgn :
                (rm == FPU_RM_RMM) ? round_bit :
                                     round_bit & (sticky_bit | in[0]);
    assign {carry, out} = {1'b0, in} + (WIDTH + 1)'(up);
endmodule

// File: rtl/itof_converter.sv
// itof_converter: 32-bit signed/unsigned integer to binary32 converter with valid/ready handshake.
// Define ITOF_OUT_REG_EN to register the rounding stage (latency 2 instead of 1).
module itof_converter
    import FPU_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    output logic        ready_out,
    output logic        valid_out,
    input  logic        ready_in,
    input  logic [4:0]  op,
    input  logic [2:0]  rm,
    input  logic [31:0] int_in,
    output logic [31:0] float_out,
    output logic        IE
);
    logic        accept, sgn, lz_zero, carry, inexact, nz, v1_q, ie_d;
    logic [31:0] mag, float_d;
    logic [4:0]  lz;
    logic [23:0] man_r;
    logic [7:0]  exp_r;
    itof_s1_t    s1_d, s1_q;

    assign ready_out = ready_in && (op == FPU_OP_CVTIF || op == FPU_OP_CVTUF);
    assign accept    = valid_in && ready_out;
    assign sgn       = (op == FPU_OP_CVTIF) && int_in[31];
    assign mag       = sgn ? -int_in : int_in;

    leading_zero_counter #(.WIDTH(32)) u_lzc (
        .in(mag),
        .count(lz),
        .zero(lz_zero)
    );

    // Bubbles carry cleared data so a held-off stage never leaks stale values.
    always_comb begin
        s1_d = '0;
        if (accept) begin
            s1_d.sgn  = sgn;
            s1_d.norm = mag << lz;
            s1_d.exp  = ITOF_EXP_BASE - {3'b0, lz};
            s1_d.zero = lz_zero;
            s1_d.rm   = rm;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1_q <= 1'b0;
            s1_q <= '0;
        end else if (ready_in) begin
            v1_q <= accept;
            s1_q <= s1_d;
        end
    end

    rounding_logic #(.WIDTH(24)) u_rnd (
        .in(s1_q.norm[31:8]),
        .sgn(s1_q.sgn),
        .round_bit(s1_q.norm[7]),
        .sticky_bit(|s1_q.norm[6:0]),
        .rm(s1_q.rm),
        .out(man_r),
        .carry(carry),
        .inexact(inexact)
    );

    // Mantissa overflow wraps man_r to zero, leaving only the exponent bump.
    assign exp_r   = s1_q.exp + {7'b0, carry};
    assign nz      = ~s1_q.zero & (man_r[23] | carry);
    assign float_d = nz ? {s1_q.sgn, exp_r, man_r[22:0]} : '0;
    assign ie_d    = nz & inexact;

`ifdef ITOF_OUT_REG_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_out <= 1'b0;
            float_out <= '0;
            IE        <= 1'b0;
        end else if (ready_in) begin
            valid_out <= v1_q;
            float_out <= float_d;
            IE        <= ie_d;
        end
    end
`else
    assign valid_out = v1_q;
    assign float_out = float_d;
    assign IE        = ie_d;
`endif
endmodule

// File: tb/tb_itof_converter.sv
// tb_itof_converter: directed-vector bench with an arithmetic reference model and scoreboard queue.
module tb_itof_converter;
    import FPU_pkg::*;

    logic        clk = 0, reset = 1, valid_in = 0, ready_in = 1;
    logic [4:0]  op = FPU_OP_CVTIF;
    logic [2:0]  rm = FPU_RM_RNE;
    logic [31:0] int_in = 0;
    logic        ready_out, valid_out, IE;
    logic [31:0] float_out;

    int          errors = 0, checks = 0;
    logic [32:0] exp_q[$];
    logic        pstall = 0;
    logic [33:0] prev = '0;

    itof_converter dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .ready_out(ready_out),
        .valid_out(valid_out), .ready_in(ready_in), .op(op), .rm(rm),
        .int_in(int_in), .float_out(float_out), .IE(IE)
    );

    always #5 clk = ~clk;

    // Returns {IE, float}; rounding decided from the exact remainder vs. one half ulp.
    function automatic logic [32:0] model(input logic [4:0] o, input logic [2:0] r, input logic [31:0] x);
        logic s, inx, up;
        logic [63:0] m, q, rem, half;
        int p, sh;
        s = (o == FPU_OP_CVTIF) && x[31];
        m = s ? 64'h1_0000_0000 - {32'b0, x} : {32'b0, x};
        if (m == 0) return '0;
        p = 32;
        while (!m[p]) p--;
        inx = 0;
        if (p <= 23) q = m << (23 - p);
        else begin
            sh = p - 23;
            q = m >> sh;
            rem = m - (q << sh);
            half = 64'd1 << (sh - 1);
            inx = rem != 0;
            case (r)
                FPU_RM_RTZ: up = 0;
                FPU_RM_RDN: up = inx && s;
                FPU_RM_RUP: up = inx && !s;
                FPU_RM_RMM: up = rem >= half;
                default:    up = rem > half || (rem == half && q[0]);
            endcase
            if (up) q = q + 1;
            if (q == 64'h100_0000) begin
                q = q >> 1;
                p++;
            end
        end
        return {inx, s, 8'(127 + p), q[22:0]};
    endfunction

    task automatic chk(input string name, input logic [33:0] act, input logic [33:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic step(input logic v, input logic [4:0] o, input logic [2:0] r, input logic [31:0] x);
        valid_in = v;
        op = o;
        rm = r;
        int_in = x;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, FPU_OP_CVTIF, FPU_RM_RNE, 0);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            pstall = 0;
        end else begin
            if (pstall) chk("stall_hold", {valid_out, IE, float_out}, prev);
            if (valid_out) begin
                if (exp_q.size() == 0) chk("spurious_valid", 34'(valid_out), 34'd0);
                else begin
                    chk("result", {IE, float_out}, exp_q[0]);
                    if (ready_in) void'(exp_q.pop_front());
                end
            end
            if (valid_in && ready_in && (op == FPU_OP_CVTIF || op == FPU_OP_CVTUF))
                exp_q.push_back(model(op, rm, int_in));
            pstall = !ready_in;
            prev = {valid_out, IE, float_out};
        end
    end

    logic [4:0]  v_op[12] = '{FPU_OP_CVTIF, FPU_OP_CVTIF, FPU_OP_CVTUF, FPU_OP_CVTUF, FPU_OP_CVTUF, FPU_OP_CVTIF,
                              FPU_OP_CVTIF, FPU_OP_CVTIF, FPU_OP_CVTIF, FPU_OP_CVTIF, FPU_OP_CVTUF, FPU_OP_CVTIF};
    logic [2:0]  v_rm[12] = '{FPU_RM_RNE, FPU_RM_RNE, FPU_RM_RUP, FPU_RM_RNE, FPU_RM_RTZ, FPU_RM_RNE,
                              FPU_RM_RUP, FPU_RM_RDN, FPU_RM_RTZ, FPU_RM_RMM, FPU_RM_RMM, 3'b110};
    logic [31:0] v_x[12]  = '{32'h80000000, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h01000001,
                              32'h01000001, 32'hFEFFFFFF, 32'hFEFFFFFF, 32'hFFFFFFFF, 32'h01000003, 32'h01000003};

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", {valid_out, IE, float_out}, 34'd0);
        reset = 0;

        chk("model_one",    model(FPU_OP_CVTIF, FPU_RM_RNE, 32'h00000001), {1'b0, 32'h3F800000});
        chk("model_intmin", model(FPU_OP_CVTIF, FPU_RM_RNE, 32'h80000000), {1'b0, 32'hCF000000});
        chk("model_umax_rne", model(FPU_OP_CVTUF, FPU_RM_RNE, 32'hFFFFFFFF), {1'b1, 32'h4F800000});
        chk("model_umax_rtz", model(FPU_OP_CVTUF, FPU_RM_RTZ, 32'hFFFFFFFF), {1'b1, 32'h4F7FFFFF});
        chk("model_tie_rne", model(FPU_OP_CVTIF, FPU_RM_RNE, 32'h01000001), {1'b1, 32'h4B800000});
        chk("model_tie_rup", model(FPU_OP_CVTIF, FPU_RM_RUP, 32'h01000001), {1'b1, 32'h4B800001});
        chk("model_neg_rdn", model(FPU_OP_CVTIF, FPU_RM_RDN, 32'hFEFFFFFF), {1'b1, 32'hCB800001});
        chk("model_neg_rtz", model(FPU_OP_CVTIF, FPU_RM_RTZ, 32'hFEFFFFFF), {1'b1, 32'hCB800000});

        valid_in = 1;
        op = FPU_OP_CVTIF;
        #1;
        chk("ready_cvtif", 34'(ready_out), 34'd1);
        step(1, FPU_OP_CVTIF, FPU_RM_RNE, 32'h00000001);
`ifdef ITOF_OUT_REG_EN
        chk("latency_early", 34'(valid_out), 34'd0);
        idle(1);
`endif
        chk("latency_one", {valid_out, IE, float_out}, {2'b10, 32'h3F800000});
        idle(3);

        for (int i = 0; i < 12; i++) step(1, v_op[i], v_rm[i], v_x[i]);
        idle(3);

        step(1, FPU_OP_CVTIF, FPU_RM_RNE, 32'd100);
        step(1, FPU_OP_CVTUF, FPU_RM_RUP, 32'h12345679);
        step(1, FPU_OP_CVTIF, FPU_RM_RDN, 32'h87654321);
        ready_in = 0;
        for (int i = 0; i < 4; i++) begin
            step(1, FPU_OP_CVTIF, FPU_RM_RNE, 32'd7);
            chk("ready_stalled", 34'(ready_out), 34'd0);
        end
        ready_in = 1;
        idle(3);

        valid_in = 1;
        op = FPU_OP_CVTFI;
        #1;
        chk("ready_cvtfi", 34'(ready_out), 34'd0);
        step(1, FPU_OP_CVTFI, FPU_RM_RNE, 32'd9);
        idle(3);

        step(1, FPU_OP_CVTIF, FPU_RM_RNE, 32'd5);
        step(1, FPU_OP_CVTUF, FPU_RM_RNE, 32'd6);
        reset = 1;
        #1;
        chk("reset_async", {valid_out, IE, float_out}, 34'd0);
        idle(2);
        reset = 0;
        idle(3);
        chk("post_reset_idle", {valid_out, IE, float_out}, 34'd0);
        chk("queue_drained", 34'(exp_q.size()), 34'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/itof_converter.md
Name: itof_converter

Overview:
- Integer-to-float converter for the FPU; the counterpart of the float-to-int path.
- Converts a 32-bit signed (FPU_OP_CVTIF) or unsigned (FPU_OP_CVTUF) integer to IEEE-754 binary32 under the requested rounding mode.
- Raises IE (inexact) when the integer is not exactly representable.
- Sits in the FPU execute stage beside the other converters and shares the valid/ready handshake and op/rm encoding with them.

Parameters:
- None. Widths are fixed at 32-bit integer and binary32.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- valid_in  in  1  upstream operand valid
- ready_out  out  1  block can accept an operand this cycle
- valid_out  out  1  result valid
- ready_in  in  1  downstream accepts the result
- op  in  5  FPU_OP_CVTIF or FPU_OP_CVTUF; any other value is not for this block
- rm  in  3  rounding mode (FPU_RM_RNE/RTZ/RDN/RUP/RMM), already resolved from dynamic mode upstream
- int_in  in  32  integer operand
- float_out  out  32  binary32 result {sgn, exp[7:0], man[22:0]}
- IE  out  1  inexact flag, qualified by valid_out

Behaviour:
- Reset is asynchronous, active-high on clk. All pipeline registers clear; valid_out=0, float_out=0, IE=0.
- ready_out = ready_in && (op==FPU_OP_CVTIF || op==FPU_OP_CVTUF). This is combinational.
- Global stall: the pipeline advances only when ready_in=1. While ready_in=0, every stage holds, and valid_out/float_out/IE stay stable.
- When ready_in=1 and no operand is accepted, a bubble enters stage 1 (valid=0, data cleared).
- Stage 1 (accept cycle, registered):
  - sgn = (op==CVTIF) && int_in[31].
  - mag = sgn ? -int_in : int_in, 32-bit unsigned; 0x80000000 negates to 0x80000000.
  - lz = leading zeros of mag (0..31). norm = mag << lz.
  - exp = 8'd158 - lz (158 = 31 + bias 127).
  - zero = (mag==0).
  - Registered alongside: sgn, norm, exp, zero, rm.
- Stage 2 (rounding):
  - man = norm[31:8]; round bit = norm[7]; sticky = |norm[6:0].
  - inexact = round | sticky.
  - Round-up decision:
    - RNE: round && (sticky || man[0]).
    - RTZ: never.
    - RDN: inexact && sgn.
    - RUP: inexact && !sgn.
    - RMM: round.
    - Reserved rm values 101/110/111 behave as RNE.
  - man+1 overflowing 24 bits gives man=0x800000 and exp+1; max case is 0xFFFFFFFF giving exp=159. No overflow to infinity is possible.
  - zero gives float_out=0x00000000 (+0.0 for both ops, every rm) and IE=0.
  - Otherwise float_out = {sgn, exp, man[22:0]} and IE = inexact.
- IV is never raised; every 32-bit integer converts validly.
- Latency is 1 cycle from accept to valid_out without ITOF_OUT_REG_EN, 2 cycles with it. Throughput is 1 per cycle while ready_in=1.
- Reset mid-operation drops all in-flight results; valid_out=0 on the next edge.

Optional Feature:
- Macro: ITOF_OUT_REG_EN.
- Defined: stage 2 is registered (float_out, IE, valid_out are flop outputs). Latency is 2, and the rounding adder is off the critical path.
- Undefined: stage 2 is combinational from the stage-1 registers; latency is 1.
- Handshake and stall rules are identical in both builds.

Decomposition:
- FPU_pkg (shared) holds:
  - FPU_OP_CVTIF and FPU_OP_CVTUF encodings;
  - FPU_RM_* encodings;
  - localparam ITOF_EXP_BASE = 8'd158.
- Sub-module leading_zero_counter #(32): combinational count plus all-zero flag. It is reusable by the normaliser in the adder path.
- Rounding reuses the existing rounding_logic #(24) with in=man, sgn, round_bit, sticky_bit, rm; its carry drives the exponent increment.

Test Plan:
- CVTIF 0x00000001 RNE -> 0x3F800000, IE=0. valid_out appears 1 cycle after accept (2 with ITOF_OUT_REG_EN).
- CVTIF 0x80000000 -> 0xCF000000, IE=0. CVTIF 0x00000000 and CVTUF 0x00000000 -> 0x00000000, IE=0.
- CVTUF 0xFFFFFFFF: RNE -> 0x4F800000, IE=1; RTZ -> 0x4F7FFFFF, IE=1.
- CVTIF 0x01000001: RNE -> 0x4B800000, IE=1; RUP -> 0x4B800001. CVTIF 0xFEFFFFFF: RDN -> 0xCB800001; RTZ -> 0xCB800000; both IE=1.
- Stall and back-to-back:
  - Stimulus: feed 3 operands on consecutive cycles, drop ready_in for 4 cycles mid-stream.
  - Required: outputs hold stable, ready_out=0 while stalled, no result lost or duplicated, order preserved.
  - Also drive op=FPU_OP_CVTFI and check ready_out=0.
- Reset mid-operation: assert reset with 2 results in flight -> valid_out=0, float_out=0, IE=0 immediately; no stale result after reset release.
